// File: rtl/intadd_pkg.sv
// -----------------------------------------------------------------------------
// intadd_pkg
// Shared definitions for the 4x32-bit integer add operand collector:
// the datapath geometry and the collector FSM state encoding.
// -----------------------------------------------------------------------------
package intadd_pkg;

    localparam int LANE_W = 32;
    localparam int LANES  = 4;
    localparam int DATA_W = LANE_W * LANES;

    typedef enum logic [2:0] {
        IDLE = 3'd0,  // waiting for an instruction
        RD0  = 3'd1,  // issue read of src0
        RD1  = 3'd2,  // issue read of src1
        WAIT = 3'd3,  // drain outstanding register-file reads
        EXEC = 3'd4,  // capture adder result
        OUT  = 3'd5   // present result until accepted
    } state_e;

endpackage : intadd_pkg

// File: rtl/intadd_rd_track.sv
// -----------------------------------------------------------------------------
// intadd_rd_track
// Shift-register tracker for fixed-latency register-file reads. Each issued
// read enters a {valid, sel} pair at stage 0; the pair reaches the last stage
// exactly RD_LAT cycles later, in the same cycle the read data is on the bus.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset, clears all stages
//   issue      in   a read is issued this cycle
//   sel        in   destination operand of the issued read (0 = op0, 1 = op1)
//   cap_valid  out  read data present this cycle
//   cap_sel    out  destination operand for the present read data
//   pend_more  out  reads still in flight besides the one being captured now
// -----------------------------------------------------------------------------
module intadd_rd_track #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic sel,
    output logic cap_valid,
    output logic cap_sel,
    output logic pend_more
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] sel_q, sel_d;
    logic [RD_LAT-1:0] vld_inner;

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (defaults first); a missed path would otherwise infer a latch.
    always_comb begin
        vld_d[0] = issue;
        sel_d[0] = sel;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            sel_d[i] = sel_q[i-1];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            sel_q <= '0;
        end else begin
            vld_q <= vld_d;
            sel_q <= sel_d;
        end
    end

    assign cap_valid = vld_q[RD_LAT-1];
    assign cap_sel   = sel_q[RD_LAT-1];

    // Everything except the output stage is still waiting for its data.
    always_comb begin
        vld_inner           = vld_q;
        vld_inner[RD_LAT-1] = 1'b0;
    end

    assign pend_more = |vld_inner;

endmodule : intadd_rd_track

// File: rtl/intadd_opnd_collect.sv
// -----------------------------------------------------------------------------
// intadd_opnd_collect
// Operand collector for the 4x32-bit integer add unit. Accepts one add
// instruction at a time, reads both 128-bit operands through a single
// fixed-latency register-file read port, drives the external combinational
// lane adder from registers, and returns the registered result with its tag
// behind a valid/ready handshake.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        instruction handshake (ready only in IDLE)
//   in_src0_idx, in_src1_idx   operand register indices
//   in_sign_s0, in_sign_s1     operand signedness flags
//   in_tag                     instruction tag
//   rf_rd_en, rf_rd_addr       register-file read request
//   rf_rd_data                 read data, valid RD_LAT cycles after rf_rd_en
//   add_src0, add_src1         operands to the adder (held from registers)
//   add_sign_s0, add_sign_s1   sign flags to the adder
//   add_dst                    combinational adder result
//   out_valid / out_ready      result handshake
//   out_dst, out_tag           registered result and its tag
// -----------------------------------------------------------------------------
module intadd_opnd_collect
    import intadd_pkg::*;
#(
    parameter int AW     = 5,
    parameter int TAG_W  = 4,
    parameter int RD_LAT = 1   // legal range 1..3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_src0_idx,
    input  logic [AW-1:0]     in_src1_idx,
    input  logic              in_sign_s0,
    input  logic              in_sign_s1,
    input  logic [TAG_W-1:0]  in_tag,

    output logic              rf_rd_en,
    output logic [AW-1:0]     rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,

    output logic [DATA_W-1:0] add_src0,
    output logic [DATA_W-1:0] add_src1,
    output logic              add_sign_s0,
    output logic              add_sign_s1,
    input  logic [DATA_W-1:0] add_dst,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_dst,
    output logic [TAG_W-1:0]  out_tag
);

    state_e             state_q, state_d;
    logic [AW-1:0]      src0_q, src0_d;
    logic [AW-1:0]      src1_q, src1_d;
    logic               sign0_q, sign0_d;
    logic               sign1_q, sign1_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [DATA_W-1:0]  op0_q, op0_d;
    logic [DATA_W-1:0]  op1_q, op1_d;
    logic [DATA_W-1:0]  out_dst_q, out_dst_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;

    logic same_idx;
    logic issue, issue_sel;
    logic cap_valid, cap_sel, pend_more;

    // A same-index instruction needs only one read; its data feeds both operands.
    assign same_idx = (src0_q == src1_q);

    intadd_rd_track #(
        .RD_LAT (RD_LAT)
    ) u_rd_track (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .sel       (issue_sel),
        .cap_valid (cap_valid),
        .cap_sel   (cap_sel),
        .pend_more (pend_more)
    );

    always_comb begin
        state_d    = state_q;
        src0_d     = src0_q;
        src1_d     = src1_q;
        sign0_d    = sign0_q;
        sign1_d    = sign1_q;
        tag_d      = tag_q;
        op0_d      = op0_q;
        op1_d      = op1_q;
        out_dst_d  = out_dst_q;
        out_tag_d  = out_tag_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        rf_rd_en   = 1'b0;
        rf_rd_addr = '0;
        issue      = 1'b0;
        issue_sel  = 1'b0;

        // Operand capture runs independently of the state: the tracker says
        // when the read bus carries data and which operand it belongs to.
        if (cap_valid) begin
            if (!cap_sel)            op0_d = rf_rd_data;
            if (cap_sel || same_idx) op1_d = rf_rd_data;
        end

        unique case (state_q)
            IDLE: begin
                // Held low during the reset cycle itself.
                in_ready = !rst;
                if (in_valid) begin
                    src0_d  = in_src0_idx;
                    src1_d  = in_src1_idx;
                    sign0_d = in_sign_s0;
                    sign1_d = in_sign_s1;
                    tag_d   = in_tag;
                    state_d = RD0;
                end
            end
            RD0: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = src0_q;
                issue      = 1'b1;
                issue_sel  = 1'b0;
                state_d    = same_idx ? WAIT : RD1;
            end
            RD1: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = src1_q;
                issue      = 1'b1;
                issue_sel  = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                // Leaves once the read being captured this cycle is the last.
                if (!pend_more) state_d = EXEC;
            end
            EXEC: begin
                out_dst_d = add_dst;
                out_tag_d = tag_q;
                state_d   = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src0_q    <= '0;
            src1_q    <= '0;
            sign0_q   <= 1'b0;
            sign1_q   <= 1'b0;
            tag_q     <= '0;
            op0_q     <= '0;
            op1_q     <= '0;
            out_dst_q <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            sign0_q   <= sign0_d;
            sign1_q   <= sign1_d;
            tag_q     <= tag_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            out_dst_q <= out_dst_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign add_src0    = op0_q;
    assign add_src1    = op1_q;
    assign add_sign_s0 = sign0_q;
    assign add_sign_s1 = sign1_q;
    assign out_dst     = out_dst_q;
    assign out_tag     = out_tag_q;

endmodule : intadd_opnd_collect
